// File: rtl/req_gnt_requester_if.sv
// ----------------------------------------------------------------------------
// req_gnt_requester_if
//
// Bundles the two handshakes of the requester stage:
//   * producer side : job_valid / job_len / job_ready (valid-ready push)
//   * granter side  : req / gnt (level request, registered grant)
//
// Modports:
//   master - the requester itself (consumes jobs, drives req, samples gnt)
//   slave  - the environment around it (producer + granter)
//
// Parameters:
//   LEN_W  width of the job length field
// ----------------------------------------------------------------------------
interface req_gnt_requester_if #(
    parameter int LEN_W = 4
);
    logic             job_valid;   // producer offers a job
    logic [LEN_W-1:0] job_len;     // cycles to hold req after grant
    logic             job_ready;   // FIFO can accept a job this cycle
    logic             req;         // request towards the granter
    logic             gnt;         // grant back from the granter

    modport master (
        input  job_valid,
        input  job_len,
        input  gnt,
        output job_ready,
        output req
    );

    modport slave (
        output job_valid,
        output job_len,
        output gnt,
        input  job_ready,
        input  req
    );
endinterface

// File: rtl/req_gnt_requester.sv
// ----------------------------------------------------------------------------
// req_gnt_requester
//
// Upstream requester stage for a registered request/grant granter. Jobs from a
// producer are queued in a small FIFO and issued one at a time: for each job
// the block raises req, waits for gnt, keeps req up for the job's length, then
// drops req and waits for gnt to fall before taking the next job. A bounded
// wait in the request phase flags grant timeouts; normal completions are
// counted.
//
// Parameters:
//   DEPTH    job FIFO entries (power of two, >= 2)
//   LEN_W    width of the job length field
//   TIMEOUT  max cycles spent requesting without gnt before abort (>= 2)
//   CNT_W    width of the completed-job counter
//
// Ports:
//   clk          clock, all flops on the rising edge
//   rstn         asynchronous active-low reset
//   bus          master side of req_gnt_requester_if
//                  job_valid/job_len in, job_ready out (push = valid & ready)
//                  req out, gnt in (granter answers one cycle after req)
//   busy         FSM not idle or FIFO not empty
//   done         one-cycle pulse per normally completed job
//   timeout_err  one-cycle pulse per job aborted by grant timeout
//   done_cnt     number of normal completions, wraps modulo 2^CNT_W
//   fifo_level   current FIFO occupancy (0..DEPTH)
// ----------------------------------------------------------------------------
module req_gnt_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    req_gnt_requester_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       done_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // A zero-length job would otherwise underflow the hold compare; it is
    // treated as the shortest legal hold of one cycle.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] raw);
        return (raw == '0) ? LEN_W'(1) : raw;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            state_q, state_d;

    logic [LEN_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push;
    logic              pop;
    logic              ready;
    logic [LEN_W-1:0]  head_len;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              abort_q, abort_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    // Readiness looks only at the registered level, so a pop in the same
    // cycle never opens a slot early; that keeps job_ready free of any
    // path from the FSM.
    assign ready    = (level_q < LVL_FULL);
    assign push     = bus.job_valid & ready;
    assign pop      = (state_q == S_IDLE) && (level_q != '0);
    assign head_len = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so natural overflow wraps the pointers.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue FSM: next state and registered pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hold_cnt_d = hold_cnt_q;
        wait_cnt_d = wait_cnt_q;
        abort_d    = abort_q;
        done_d     = 1'b0;
        terr_d     = 1'b0;
        done_cnt_d = done_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    len_d      = norm_len(head_len);
                    wait_cnt_d = '0;
                    abort_d    = 1'b0;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (bus.gnt) begin
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            // The grant is not re-checked here: once granted, the job owns
            // the resource for its full length.
            S_HOLD: begin
                if (hold_cnt_q == len_q - LEN_W'(1)) begin
                    abort_d = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + LEN_W'(1);
                end
            end

            // Leave only after the granter has visibly let go, so the next
            // request can never be mistaken for a stale grant.
            S_RELEASE: begin
                if (!bus.gnt) begin
                    state_d = S_IDLE;
                    if (!abort_q) begin
                        done_d     = 1'b1;
                        done_cnt_d = done_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Data registers (no reset: only read after being written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.job_len;
        end
        len_q <= len_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // req is a pure decode of the state register, so an asynchronous reset
    // drops it immediately.
    assign bus.req       = (state_q == S_REQ) || (state_q == S_HOLD);
    assign bus.job_ready = ready;
    assign busy          = (state_q != S_IDLE) || (level_q != '0);
    assign done          = done_q;
    assign timeout_err   = terr_q;
    assign done_cnt      = done_cnt_q;
    assign fifo_level    = level_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_pulse_exclusive: assert property (
        @(posedge clk) disable iff (!rstn) !(done_q && terr_q)
    );

    a_level_bounded: assert property (
        @(posedge clk) disable iff (!rstn) level_q <= LVL_FULL
    );

endmodule
